// File: rtl/lane_pkt_pkg.sv
// Shared K-codes, checker FSM states and error codes for the lane packet checker.
package lane_pkt_pkg;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOP   = 8'hFB;
  localparam logic [7:0] K_EOP   = 8'hFD;

  localparam int unsigned LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_PAYLOAD,
    ST_EOPCHK
  } state_t;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_DATA   = 3'd1;
  localparam logic [2:0] ERR_KCHAR  = 3'd2;
  localparam logic [2:0] ERR_NO_EOP = 3'd3;
  localparam logic [2:0] ERR_LEN    = 3'd4;
  localparam logic [2:0] ERR_SOP    = 3'd5;

  // A byte only counts as a K-code when its control flag is set.
  function automatic logic is_kchar(input logic [7:0] b, input logic k, input logic [7:0] code);
    return k && (b == code);
  endfunction

endpackage

// File: rtl/lane_byte_aligner.sv
// Comma-based byte aligner: locks the K28.5 lane while the checker is idle and
// rotates the stream so that lane becomes byte 0, one register stage deep.
module lane_byte_aligner
  import lane_pkt_pkg::*;
#(
  parameter int unsigned BYTES = 4
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic [8*BYTES-1:0]   gt_data,
  input  logic [BYTES-1:0]     gt_ctrl,
  input  logic                 relock_en,
  output logic                 aligned,
  output logic [8*BYTES-1:0]   word_data,
  output logic [BYTES-1:0]     word_ctrl
);

  localparam int unsigned W     = 8 * BYTES;
  localparam int unsigned OFS_W = $clog2(BYTES);

  logic [OFS_W-1:0]   offset;
  logic [W-1:0]       prev_data;
  logic [BYTES-1:0]   prev_ctrl;
  logic               hit;
  logic [OFS_W-1:0]   hit_lane;
  logic [2*W-1:0]     join_data;
  logic [2*BYTES-1:0] join_ctrl;
  logic [W-1:0]       rot_data;
  logic [BYTES-1:0]   rot_ctrl;

  // Scan from the top lane down so the lowest matching lane wins.
  always_comb begin
    hit      = 1'b0;
    hit_lane = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (is_kchar(gt_data[8*i +: 8], gt_ctrl[i], K_COMMA)) begin
        hit      = 1'b1;
        hit_lane = OFS_W'(i);
      end
    end
  end

  // Offset k>0 takes lanes k.. of the previous word plus lanes ..k-1 of the current one.
  always_comb begin
    join_data = {gt_data, prev_data};
    join_ctrl = {gt_ctrl, prev_ctrl};
    if (offset == '0) begin
      rot_data = gt_data;
      rot_ctrl = gt_ctrl;
    end else begin
      rot_data = W'(join_data >> (8 * offset));
      rot_ctrl = BYTES'(join_ctrl >> offset);
    end
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      offset    <= '0;
      aligned   <= 1'b0;
      prev_data <= '0;
      prev_ctrl <= '0;
      word_data <= '0;
      word_ctrl <= '0;
    end else begin
      prev_data <= gt_data;
      prev_ctrl <= gt_ctrl;
      word_data <= rot_data;
      word_ctrl <= rot_ctrl;
      if (relock_en && hit) begin
        offset  <= hit_lane;
        aligned <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_packet_checker.sv
// Receive-side packet checker: aligns the GT lane, parses SOP/len/payload/EOP
// framing, checks the payload pattern and keeps saturating good/bad counters.
module lane_packet_checker
  import lane_pkt_pkg::*;
#(
  parameter int unsigned BYTES   = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned PATTERN = 0
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic [8*BYTES-1:0]   gt_rx_data,
  input  logic [BYTES-1:0]     gt_rx_ctrl,
  output logic                 aligned,
  output logic                 pkt_done,
  output logic                 pkt_err,
  output logic [2:0]           err_code,
  output logic [7:0]           last_type,
  output logic [CNT_W-1:0]     packet_cnt_o,
  output logic [CNT_W-1:0]     error_packet_cnt_o
);

  localparam int unsigned W = 8 * BYTES;

  logic [W-1:0]      a_data;
  logic [BYTES-1:0]  a_ctrl;

  state_t            state, state_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic [LEN_W-1:0]  hdr_len;
  logic [W-1:0]      seed, seed_n;
  logic [W-1:0]      expect_word;
  logic [2:0]        pend, pend_n;
  logic [2:0]        err_code_n;
  logic [7:0]        last_type_n;
  logic              pkt_done_n, pkt_err_n;
  logic [CNT_W-1:0]  pcnt_n, ecnt_n;

  logic              sop, eop_ok, any_k;
  logic              start_sop, load_len, fail;
  logic [2:0]        fail_code;

  lane_byte_aligner #(
    .BYTES (BYTES)
  ) u_aligner (
    .rx_clk    (rx_clk),
    .rst       (rst),
    .gt_data   (gt_rx_data),
    .gt_ctrl   (gt_rx_ctrl),
    .relock_en (state == ST_IDLE),
    .aligned   (aligned),
    .word_data (a_data),
    .word_ctrl (a_ctrl)
  );

  // Word decode on the aligned stream.
  always_comb begin
    sop         = aligned && is_kchar(a_data[7:0], a_ctrl[0], K_SOP);
    eop_ok      = is_kchar(a_data[7:0], a_ctrl[0], K_EOP) && (a_ctrl[BYTES-1:1] == '0);
    any_k       = |a_ctrl;
    hdr_len     = (BYTES == 2) ? LEN_W'(a_data) : LEN_W'(a_data >> 16);
    expect_word = (PATTERN == 0) ? {BYTES{seed[7:0]}} : seed;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    len_n       = len;
    cnt_n       = cnt;
    seed_n      = seed;
    pend_n      = pend;
    pkt_done_n  = 1'b0;
    pkt_err_n   = 1'b0;
    err_code_n  = err_code;
    last_type_n = last_type;
    pcnt_n      = packet_cnt_o;
    ecnt_n      = error_packet_cnt_o;
    start_sop   = 1'b0;
    load_len    = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_NONE;

    case (state)
      ST_IDLE: begin
        if (sop) start_sop = 1'b1;
      end
      ST_HDR2: begin
        if (sop) begin
          fail      = 1'b1;
          fail_code = ERR_SOP;
          start_sop = 1'b1;
        end else if (any_k) begin
          fail      = 1'b1;
          fail_code = ERR_KCHAR;
          state_n   = ST_IDLE;
        end else begin
          load_len = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (sop) begin
          fail      = 1'b1;
          fail_code = ERR_SOP;
          start_sop = 1'b1;
        end else if (any_k) begin
          fail      = 1'b1;
          fail_code = ERR_KCHAR;
          state_n   = ST_IDLE;
        end else begin
          if ((a_data != expect_word) && (pend == ERR_NONE)) pend_n = ERR_DATA;
          seed_n = seed + W'(1);
          cnt_n  = cnt + LEN_W'(1);
          if (cnt_n == len) state_n = ST_EOPCHK;
        end
      end
      ST_EOPCHK: begin
        if (sop) begin
          fail      = 1'b1;
          fail_code = ERR_SOP;
          start_sop = 1'b1;
        end else if (eop_ok && (pend == ERR_NONE)) begin
          pkt_done_n = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          fail      = 1'b1;
          fail_code = ERR_NO_EOP;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (start_sop) begin
      last_type_n = a_data[15:8];
      seed_n      = '0;
      cnt_n       = '0;
      pend_n      = ERR_NONE;
      if (BYTES == 2) state_n = ST_HDR2;
      else            load_len = 1'b1;
    end

    // A bad length on a back-to-back SOP cannot pulse twice; defer it to EOPCHK.
    if (load_len) begin
      len_n = hdr_len;
      if (32'(hdr_len) > 32'(MAX_LEN)) begin
        if (fail) begin
          pend_n  = ERR_LEN;
          state_n = ST_EOPCHK;
        end else begin
          fail      = 1'b1;
          fail_code = ERR_LEN;
          state_n   = ST_IDLE;
        end
      end else if (hdr_len == '0) begin
        state_n = ST_EOPCHK;
      end else begin
        state_n = ST_PAYLOAD;
      end
    end

    if (fail) begin
      pkt_err_n  = 1'b1;
      err_code_n = (pend != ERR_NONE) ? pend : fail_code;
    end

    if (pkt_done_n && (packet_cnt_o != '1))      pcnt_n = packet_cnt_o + CNT_W'(1);
    if (pkt_err_n && (error_packet_cnt_o != '1)) ecnt_n = error_packet_cnt_o + CNT_W'(1);
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      len                <= '0;
      cnt                <= '0;
      seed               <= '0;
      pend               <= ERR_NONE;
      pkt_done           <= 1'b0;
      pkt_err            <= 1'b0;
      err_code           <= ERR_NONE;
      last_type          <= '0;
      packet_cnt_o       <= '0;
      error_packet_cnt_o <= '0;
    end else begin
      state              <= state_n;
      len                <= len_n;
      cnt                <= cnt_n;
      seed               <= seed_n;
      pend               <= pend_n;
      pkt_done           <= pkt_done_n;
      pkt_err            <= pkt_err_n;
      err_code           <= err_code_n;
      last_type          <= last_type_n;
      packet_cnt_o       <= pcnt_n;
      error_packet_cnt_o <= ecnt_n;
    end
  end

endmodule

// File: doc/lane_packet_checker.md
LANE_PACKET_CHECKER -- requirements
Module: lane_packet_checker

Interface
REQ-001 SHALL have parameter BYTES, default 4, bytes per GT user word (legal 2 or 4); data width W = 8*BYTES.
REQ-002 SHALL have parameter CNT_W, default 32, width of the status counters.
REQ-003 SHALL have parameter MAX_LEN, default 1024, maximum legal payload length in words.
REQ-004 SHALL have parameter PATTERN, default 0, payload pattern: 0 = 8-bit counter replicated in every byte, 1 = W-bit incrementing word.
REQ-005 SHALL have port rx_clk, input, 1, sole clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port gt_rx_data, input, W, raw GT receive word.
REQ-008 SHALL have port gt_rx_ctrl, input, BYTES, per-byte K-char flags.
REQ-009 SHALL have port aligned, output, 1, comma lane locked.
REQ-010 SHALL have port pkt_done, output, 1, one-cycle pulse when a good packet ends.
REQ-011 SHALL have port pkt_err, output, 1, one-cycle pulse when a bad packet is terminated.
REQ-012 SHALL have port err_code, output, 3, cause of the last error, held until the next error.
REQ-013 SHALL have port last_type, output, 8, type byte of the last SOP.
REQ-014 SHALL have port packet_cnt_o, output, CNT_W, count of good packets.
REQ-015 SHALL have port error_packet_cnt_o, output, CNT_W, count of bad packets.

Function
REQ-016 SHALL treat K28.5 = 0xBC, SOP = K27.7 = 0xFB and EOP = K29.7 = 0xFD; a byte is a K-char only when its ctrl bit is 1.
REQ-017 Aligner SHALL lock the lane offset k of any K28.5 found in IDLE and then set aligned=1; the lowest lane wins when several match.
REQ-018 Aligner SHALL output bytes rotated so the comma lane maps to byte 0, joining the previous and current words, with a fixed 1-cycle latency.
REQ-019 Aligner SHALL NOT change offset outside IDLE; a comma found at a different lane while in IDLE SHALL relock, with aligned staying 1.
REQ-020 Aligned word format: SOP word = byte0 SOP, byte1 type, bytes[BYTES-1:2] length (for BYTES=2, length is taken from the next word's low 16 bits, with state HDR2).
REQ-021 FSM states SHALL be IDLE, HDR2 (BYTES=2 only), PAYLOAD and EOPCHK.
REQ-022 IDLE SHALL go to PAYLOAD (or HDR2) on a valid SOP word, latching len and last_type; if len==0 it SHALL go to EOPCHK.
REQ-023 PAYLOAD SHALL compare each word with the expected pattern (seed 0 at each SOP, +1 per word, wrapping mod 256 or mod 2^W), and go to EOPCHK after len words.
REQ-024 EOPCHK SHALL pulse pkt_done and return to IDLE if byte0 is EOP with all other ctrl bits 0 and no error latched; otherwise it SHALL pulse pkt_err.
REQ-025 err_code SHALL be: 1 data mismatch, 2 K-char inside payload, 3 missing EOP, 4 len > MAX_LEN, 5 SOP received while not IDLE.
REQ-026 Data mismatch SHALL latch an error but continue to EOPCHK; codes 2, 4 and 5 SHALL terminate immediately (pkt_err pulse), and code 5 SHALL re-enter as a new SOP in the same cycle.
REQ-027 Only the first error per packet SHALL set err_code; exactly one pkt_done or pkt_err pulse SHALL occur per SOP.
REQ-028 Counters SHALL increment on pkt_done or pkt_err and SHALL saturate at all-ones.
REQ-029 Loss of lock (rst) SHALL abandon any packet in progress without incrementing any counter.
REQ-030 Latency from the EOP word at the input to the pkt_done pulse SHALL be 2 cycles.

Reset
REQ-031 On rst=1, outputs SHALL be aligned=0, pkt_done=0, pkt_err=0, err_code=0, last_type=0 and both counters=0; FSM SHALL be IDLE, offset 0 and pattern seed 0.
REQ-032 rst SHALL assert asynchronously and release synchronously to rx_clk, with behaviour taking effect from the first edge after release.

Structure
REQ-033 Package lane_pkt_pkg SHALL hold the K-code constants, the state enum and the err_code constants.
REQ-034 Sub-module lane_byte_aligner (parameter BYTES) SHALL implement REQ-017 to REQ-019; the FSM and counters SHALL sit in the top.

Verification
REQ-035 BYTES=4, comma in lane 2 then SOP type 8 len 256 with the byte-counter payload and EOP -> aligned=1, pkt_done once, packet_cnt_o=1, last_type=8.
REQ-036 Payload word 17 corrupted to 0x00000000 -> pkt_err at EOP, err_code=1, error_packet_cnt_o=1, next good packet counted.
REQ-037 SOP len 2000 (MAX_LEN 1024) -> immediate pkt_err, err_code=4, FSM back to IDLE.
REQ-038 Second SOP injected at payload word 10 -> pkt_err, err_code=5, second packet completes with pkt_done.
REQ-039 CNT_W=4, 20 good packets -> packet_cnt_o saturates at 15.
REQ-040 rst pulsed mid-payload -> all outputs zero immediately, aligned=0 until the next comma, counters unchanged afterwards.
